// File: rtl/vendor_panel_in.sv
// vendor_panel_in
//   Front-panel input conditioner for the vending-machine core. The nine raw,
//   active-low push-buttons are synchronised and debounced. A one-hot goods
//   selection and a coin code are latched. A timed active-low confirm strobe
//   (suren) is issued only when both goods and money are selected.
//
//   Ports:
//     clk_1kHz    in   1  scan clock; all logic on its rising edge
//     rst         in   1  synchronous reset, active-high
//     key_goods   in   4  raw goods buttons, active-low, asynchronous
//     key_coin    in   3  raw coin buttons, active-low, asynchronous
//     key_ok      in   1  raw confirm button, active-low, asynchronous
//     key_cancel  in   1  raw cancel button, active-low, asynchronous
//     goods       out  4  latched one-hot goods selection (0 = none)
//     money       out  3  latched coin code (0 = none)
//     suren       out  1  confirm strobe, active-low
//     busy        out  1  high while confirming or waiting for key release
//     err         out  1  one-cycle pulse when a confirm is rejected
//
//   Optional build macro PANEL_AUTOCLR_EN: when defined, goods and money clear
//   at the edge where suren returns high, so the lock phase exits to IDLE.
//   When undefined, the selection is held after a confirm.
module vendor_panel_in #(
    parameter int DEB_CNT   = 20,
    parameter int SUREN_LEN = 2
) (
    input  logic       clk_1kHz,
    input  logic       rst,
    input  logic [3:0] key_goods,
    input  logic [2:0] key_coin,
    input  logic       key_ok,
    input  logic       key_cancel,
    output logic [3:0] goods,
    output logic [2:0] money,
    output logic       suren,
    output logic       busy,
    output logic       err
);

    localparam int NK = 9;

    typedef enum logic [1:0] {IDLE, SEL, CONFIRM, LOCK} state_t;

    // Key bit map: [3:0] goods, [6:4] coin, [7] ok, [8] cancel.
    logic [NK-1:0] raw;
    logic [NK-1:0] sync_p0, sync_p1;
    logic [NK-1:0] deb_lvl;   // 1 = pressed
    logic [NK-1:0] deb_dly;
    logic [NK-1:0] press;
    logic [7:0]    deb_cnt [NK];

    state_t     state, state_n;
    logic [3:0] goods_n;
    logic [2:0] money_n;
    logic       suren_n, err_n;
    logic [3:0] len, len_n;

    logic [3:0] ev_goods;
    logic [2:0] ev_coin;
    logic       ev_ok, ev_cancel;

    // Lowest pressed goods index wins.
    function automatic logic [3:0] pick_goods(input logic [3:0] g);
        return g & (~g + 4'd1);
    endfunction

    // Highest pressed coin index wins; code is index + 1.
    function automatic logic [2:0] pick_coin(input logic [2:0] c);
        if (c[2])      return 3'd3;
        else if (c[1]) return 3'd2;
        else if (c[0]) return 3'd1;
        else           return 3'd0;
    endfunction

    assign raw = {key_cancel, key_ok, key_coin, key_goods};

    // ---- stage p0/p1: two-flop synchroniser (resets to "released") ----
    always_ff @(posedge clk_1kHz) begin
        if (rst) begin
            sync_p0 <= '1;
            sync_p1 <= '1;
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
        end
    end

    // ---- debounce: count disagreement, flip the level on reaching DEB_CNT ----
    always_ff @(posedge clk_1kHz) begin
        if (rst) begin
            deb_lvl <= '0;
            deb_dly <= '0;
            for (int i = 0; i < NK; i++) deb_cnt[i] <= '0;
        end else begin
            deb_dly <= deb_lvl;
            for (int i = 0; i < NK; i++) begin
                if (deb_cnt[i] == 8'(DEB_CNT)) begin
                    deb_lvl[i] <= ~deb_lvl[i];
                    deb_cnt[i] <= '0;
                end else if (~sync_p1[i] != deb_lvl[i]) begin
                    deb_cnt[i] <= deb_cnt[i] + 8'd1;
                end else begin
                    deb_cnt[i] <= '0;
                end
            end
        end
    end

    // Press event: one cycle after a released->pressed flip; releases are silent.
    assign press     = deb_lvl & ~deb_dly;
    assign ev_goods  = press[3:0];
    assign ev_coin   = press[6:4];
    assign ev_ok     = press[7];
    assign ev_cancel = press[8];

    // ---- control FSM ----
    always_ff @(posedge clk_1kHz) begin
        if (rst) begin
            state <= IDLE;
            goods <= '0;
            money <= '0;
            suren <= 1'b1;
            err   <= 1'b0;
            len   <= '0;
        end else begin
            state <= state_n;
            goods <= goods_n;
            money <= money_n;
            suren <= suren_n;
            err   <= err_n;
            len   <= len_n;
        end
    end

    always_comb begin
        state_n = state;
        goods_n = goods;
        money_n = money;
        suren_n = suren;
        len_n   = len;
        err_n   = 1'b0;
        case (state)
            IDLE, SEL: begin
                // Only the highest-priority event class acts in a cycle.
                if (ev_cancel) begin
                    goods_n = '0;
                    money_n = '0;
                    state_n = IDLE;
                end else if (ev_ok) begin
                    if (state == SEL && goods != '0 && money != '0) begin
                        suren_n = 1'b0;
                        len_n   = 4'(SUREN_LEN);
                        state_n = CONFIRM;
                    end else begin
                        err_n = 1'b1;
                    end
                end else if (ev_coin != '0) begin
                    money_n = pick_coin(ev_coin);
                    state_n = SEL;
                end else if (ev_goods != '0) begin
                    goods_n = pick_goods(ev_goods);
                    state_n = SEL;
                end
            end
            CONFIRM: begin
                if (len == 4'd1) begin
                    suren_n = 1'b1;
                    state_n = LOCK;
`ifdef PANEL_AUTOCLR_EN
                    goods_n = '0;
                    money_n = '0;
`endif
                end else begin
                    len_n = len - 4'd1;
                end
            end
            LOCK: begin
                // Wait for every key to release so a held ok cannot retrigger.
                if (deb_lvl == '0)
                    state_n = (goods != '0 || money != '0) ? SEL : IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy = (state == CONFIRM) || (state == LOCK);

endmodule

// File: tb/tb_vendor_panel_in.sv
// Directed testbench for vendor_panel_in with DEB_CNT=4, SUREN_LEN=2.
// A key driven low before edge k gives its output change at edge k+7.
module tb_vendor_panel_in;

    logic       clk_1kHz = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] key_goods = 4'hF;
    logic [2:0] key_coin = 3'h7;
    logic       key_ok = 1'b1;
    logic       key_cancel = 1'b1;
    logic [3:0] goods;
    logic [2:0] money;
    logic       suren, busy, err;

    int n_checks = 0;
    int n_errors = 0;

    vendor_panel_in #(.DEB_CNT(4), .SUREN_LEN(2)) dut (
        .clk_1kHz  (clk_1kHz),
        .rst       (rst),
        .key_goods (key_goods),
        .key_coin  (key_coin),
        .key_ok    (key_ok),
        .key_cancel(key_cancel),
        .goods     (goods),
        .money     (money),
        .suren     (suren),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk_1kHz = ~clk_1kHz;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_1kHz);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    initial begin
        // Reset
        ticks(3);
        check("rst_goods", goods, 0);
        check("rst_money", money, 0);
        check("rst_suren", suren, 1);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        rst = 1'b0;
        tick();

        // Goods[1] latency: change exactly at edge k+7
        key_goods = 4'b1101;
        ticks(7);
        check("lat_goods_early", goods, 0);
        tick();
        check("lat_goods", goods, 4'b0010);
        key_goods = 4'hF;
        ticks(10);

        // 3-cycle glitch on goods[2] is rejected
        key_goods = 4'b1011;
        ticks(3);
        key_goods = 4'hF;
        ticks(12);
        check("glitch_goods", goods, 4'b0010);

        // Selection replacement, coin[2], goods[1]
        key_goods = 4'b0111;
        ticks(8);
        check("sel_goods3", goods, 4'b1000);
        key_goods = 4'hF;
        ticks(10);
        key_coin = 3'b011;
        ticks(8);
        check("sel_coin2", money, 3'b011);
        key_coin = 3'h7;
        ticks(10);
        key_goods = 4'b1101;
        ticks(8);
        check("sel_goods1", goods, 4'b0010);
        key_goods = 4'hF;
        ticks(10);

        // Confirm: suren low for two cycles from edge k+7
        key_ok = 1'b0;
        ticks(7);
        check("cfm_suren_pre", suren, 1);
        check("cfm_busy_pre", busy, 0);
        tick();
        check("cfm_suren_lo1", suren, 0);
        check("cfm_busy", busy, 1);
        check("cfm_err", err, 0);
        tick();
        check("cfm_suren_lo2", suren, 0);
        tick();
        check("cfm_suren_hi", suren, 1);
        check("cfm_busy_lock", busy, 1);
`ifdef PANEL_AUTOCLR_EN
        check("cfm_goods_after", goods, 0);
        check("cfm_money_after", money, 0);
`else
        check("cfm_goods_after", goods, 4'b0010);
        check("cfm_money_after", money, 3'b011);
`endif
        ticks(5);
        check("lock_held_ok", busy, 1);
        check("lock_no_retrig", suren, 1);
        key_ok = 1'b1;
        ticks(7);
        check("lock_release_early", busy, 1);
        tick();
        check("lock_release", busy, 0);
        ticks(3);

        // Cancel clears, then ok with goods only -> err
        key_cancel = 1'b0;
        ticks(8);
        check("cancel_goods", goods, 0);
        check("cancel_money", money, 0);
        key_cancel = 1'b1;
        ticks(10);
        key_goods = 4'b1011;
        ticks(8);
        check("err_sel_goods", goods, 4'b0100);
        key_goods = 4'hF;
        ticks(10);
        key_ok = 1'b0;
        ticks(7);
        check("err_pre", err, 0);
        tick();
        check("err_pulse", err, 1);
        check("err_suren", suren, 1);
        check("err_goods", goods, 4'b0100);
        tick();
        check("err_single", err, 0);
        key_ok = 1'b1;
        ticks(10);

        // Simultaneous cancel+ok in SEL: cancel wins, no strobe
        key_coin = 3'b110;
        ticks(8);
        check("sim_coin0", money, 3'b001);
        key_coin = 3'h7;
        ticks(10);
        key_cancel = 1'b0;
        key_ok = 1'b0;
        ticks(8);
        check("sim_goods", goods, 0);
        check("sim_money", money, 0);
        check("sim_suren", suren, 1);
        check("sim_err", err, 0);
        tick();
        check("sim_suren2", suren, 1);
        key_cancel = 1'b1;
        key_ok = 1'b1;
        ticks(10);

        // Goods tie: lowest index; coin tie: highest index
        key_goods = 4'b0110;
        ticks(8);
        check("tie_goods", goods, 4'b0001);
        key_goods = 4'hF;
        ticks(10);
        key_coin = 3'b010;
        ticks(8);
        check("tie_coin", money, 3'b011);
        key_coin = 3'h7;
        ticks(10);
        key_coin = 3'b101;
        ticks(8);
        check("coin1", money, 3'b010);
        key_coin = 3'h7;
        ticks(10);

        // Reset in the cycle after suren falls, ok held through it
        key_ok = 1'b0;
        ticks(8);
        check("rstc_suren_lo", suren, 0);
        rst = 1'b1;
        tick();
        check("rstc_suren", suren, 1);
        check("rstc_goods", goods, 0);
        check("rstc_money", money, 0);
        check("rstc_busy", busy, 0);
        rst = 1'b0;
        ticks(7);
        check("rstc_err_pre", err, 0);
        tick();
        check("rstc_err", err, 1);
        check("rstc_no_suren", suren, 1);
        tick();
        check("rstc_err_end", err, 0);
        key_ok = 1'b1;
        ticks(5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
